// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// Ownership ends on release, when the owner drops its request, or when MAX_HOLD expires.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] request,
  // 'release' is a reserved word in SystemVerilog, hence the suffix
  input  logic       release_in,
  output logic [3:0] grant,
  output logic [1:0] grant_index,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned REQ_N  = 4;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic [3:0]        grant_q,   grant_d;
  logic [1:0]        index_q,   index_d;
  logic              valid_q,   valid_d;
  logic              timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic [1:0]        last_q,    last_d;

  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              expired;
  logic              owner_req;

  // Rotating search starting just after the previous owner
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int i = 1; i <= int'(REQ_N); i++) begin
      logic [1:0] cand;
      cand = 2'(last_q + 2'(i));
      if (!pick_found && request[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign expired   = (hold_q == HOLD_MAX);
  assign owner_req = request[index_q];

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          index_d = pick_idx;
          valid_d = 1'b1;
          hold_d  = HOLD_W'(1);
        end
      end
      BUSY: begin
        if (release_in || !owner_req || expired) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          hold_d    = '0;
          last_d    = index_q;
          // release wins over expiry; a dropped request is a normal end
          timeout_d = expired && !release_in && owner_req;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
    grant_d = valid_d ? 4'(4'b0001 << index_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      index_q   <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      last_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_index = index_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] request;
  logic       release_in;
  logic [3:0] grant;
  logic [1:0] grant_index;
  logic       grant_valid;
  logic       timeout;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .release_in  (release_in),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  typedef struct {
    int unsigned cyc;
    logic [3:0]  g;
    logic [1:0]  i;
    logic        v;
    logic        t;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc_cnt = 0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: compare every queued expectation in the cycle it targets
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc != cyc_cnt) begin
        chk("stale_expectation", 8'(cyc_cnt), 8'(e.cyc));
      end else begin
        chk("grant",       8'(grant),       8'(e.g));
        chk("grant_index", 8'(grant_index), 8'(e.i));
        chk("grant_valid", 8'(grant_valid), 8'(e.v));
        chk("timeout",     8'(timeout),     8'(e.t));
      end
    end
  end

  // Called at posedge+1: drive inputs, expect outputs after the next edge
  task automatic step(input logic [3:0] rq, input logic rl,
                      input logic [3:0] eg, input logic [1:0] ei,
                      input logic ev, input logic et);
    exp_t e;
    request    = rq;
    release_in = rl;
    e.cyc = cyc_cnt + 1;
    e.g = eg; e.i = ei; e.v = ev; e.t = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"},       8'(grant),       8'd0);
    chk({tag, "_grant_index"}, 8'(grant_index), 8'd0);
    chk({tag, "_grant_valid"}, 8'(grant_valid), 8'd0);
    chk({tag, "_timeout"},     8'(timeout),     8'd0);
  endtask

  initial begin
    request    = 4'b0000;
    release_in = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round robin with release each grant, starting at requester 0
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    // release while idle has no effect
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold expiry: 8 grant cycles, then a timeout pulse
    for (int k = 0; k < 8; k++) step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Release coinciding with expiry: no timeout
    for (int k = 0; k < 8; k++) step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Owner drops its request; requester 0 follows after one idle cycle
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    // non-owner request changes are ignored
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Mid-grant asynchronous reset
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    drain();
    #2;
    rst_n   = 1'b0;
    request = 4'b0000;
    #1 chk_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    chk_zero("held_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of cycles one grant is held (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port request, input, 4 bits: request[i] high means requester i wants the shared resource.
REQ-005 SHALL have port release, input, 1 bit: the current owner finished and frees the resource.
REQ-006 SHALL have port grant, output reg, 4 bits: one-hot owner (00->0001, 01->0010, 10->0100, 11->1000), or 0000 when there is no owner.
REQ-007 SHALL have port grant_index, output reg, 2 bits: binary index of the owner.
REQ-008 SHALL have port grant_valid, output reg, 1 bit: high while a grant is active.
REQ-009 SHALL have port timeout, output reg, 1 bit: one-cycle pulse when a grant ends because MAX_HOLD expired.

Function
REQ-010 SHALL implement two states, IDLE and BUSY, all outputs registered on clk.
REQ-011 SHALL keep a 2-bit last_index pointer; search order starts at last_index+1 and wraps modulo 4 (e.g. last=2 -> search order 3,0,1,2).
REQ-012 SHALL, in IDLE with request!=0 at rising edge N, enter BUSY at edge N and drive grant, grant_index and grant_valid=1 from the cycle after edge N (1-cycle latency).
REQ-013 SHALL derive grant only as the one-hot decode of grant_index; grant and grant_index SHALL never disagree.
REQ-014 SHALL, in IDLE with request==0, stay in IDLE with grant=0000 and grant_valid=0.
REQ-015 SHALL use an 8-bit hold counter that loads 1 on grant entry and increments once per BUSY cycle.
REQ-016 SHALL end a grant at the edge where release=1, or the owner's request bit=0, or hold count==MAX_HOLD.
REQ-017 SHALL, when a grant ends, return to IDLE, clear grant, grant_valid and hold counter, and set last_index to the ended grant_index.
REQ-018 SHALL insert exactly one idle cycle (grant=0000) between consecutive grants.
REQ-019 SHALL pulse timeout=1 for one cycle, the cycle after the ending edge, only when MAX_HOLD expired with release=0 and the owner's request=1.
REQ-020 SHALL give release priority when release and expiry coincide: the grant ends and no timeout pulse is produced.
REQ-021 SHALL ignore release while in IDLE.
REQ-022 SHALL ignore changes to non-owner request bits while in BUSY.
REQ-023 SHALL keep grant_index at its last value during IDLE, while grant_valid=0 marks it don't-care.
REQ-024 SHALL, with MAX_HOLD=1, end every grant after exactly one BUSY cycle.

Reset
REQ-025 SHALL, on rst_n=0 and without waiting for clk, force state=IDLE, grant=0000, grant_index=00, grant_valid=0, timeout=0, hold counter=0, last_index=11 (requester 0 has top priority after reset).
REQ-026 SHALL, when reset is asserted mid-grant, drop the grant immediately and emit no timeout pulse.
REQ-027 SHALL start normal arbitration at the first rising clk edge after rst_n deasserts.

Verification
REQ-028 SHALL cover: reset release, then request=1111 -> grant=0001, grant_index=00 one cycle later.
REQ-029 SHALL cover: request=1111 held and release pulsed each grant -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-030 SHALL cover: MAX_HOLD=8, request=0100 held, release=0 -> grant=0100 for exactly 8 cycles, timeout=1 for one cycle, then 0000.
REQ-031 SHALL cover: release=1 on the same edge the hold count reaches 8 -> grant drops and timeout stays 0.
REQ-032 SHALL cover: owner 2 drops request[2] mid-grant while request[0] is high -> grant=0000 for one cycle, then grant=0001.
REQ-033 SHALL cover: rst_n=0 asserted between edges during grant=1000 -> all outputs zero immediately; after deassertion, request=1000 -> grant=1000.
